// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the 5-stage pipeline hazard controller and its forwarding unit.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        PC_WAIT  = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [3:0] R15 = 4'hF;

endpackage

// File: rtl/pipeline_hazard_ctrl_forward_unit.sv
// Execute-stage operand forwarding select: M beats W, R15 always comes from the register file.
module forward_unit
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [3:0] ra,
    input  logic [3:0] wa_m,
    input  logic [3:0] wa_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    output logic [1:0] fwd
);

    always_comb begin
        fwd = FWD_RF;
        if (ra != R15) begin
            if (reg_write_m && (wa_m == ra)) begin
                fwd = FWD_M;
            end else if (reg_write_w && (wa_w == ra)) begin
                fwd = FWD_W;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the F/D/E/M/W pipe: memory wait, PC-write drain, mispredict and load-use.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64,
    parameter int PCW_DEPTH   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic [3:0]       RA1E,
    input  logic [3:0]       RA2E,
    input  logic [3:0]       WA3E,
    input  logic [3:0]       WA3M,
    input  logic [3:0]       WA3W,
    input  logic             MemtoRegE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcD,
    input  logic             PCWrPendingW,
    input  logic             MispredictE,
    input  logic             MemAccessM,
    input  logic             mem_ready,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic             mem_err
);

    localparam int PCW_W = $clog2(PCW_DEPTH + 1);
    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [PCW_W-1:0] PCW_MAX  = PCW_W'(PCW_DEPTH);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [PCW_W-1:0] pcw_cnt;
    logic [PCW_W-1:0] pcw_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             pending_mispredict;
    logic             mem_hold;
    logic             timeout_hit;
    logic             mispredict_apply;
    logic             load_use;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && !(&v)) ? v + 1'b1 : v;
    endfunction

    function automatic logic [PCW_W-1:0] pcw_step(input logic [PCW_W-1:0] v,
                                                  input logic inc, input logic dec);
        logic [PCW_W-1:0] r;
        r = v;
        if (inc && !dec && (v != PCW_MAX)) begin
            r = v + 1'b1;
        end else if (dec && !inc && (v != '0)) begin
            r = v - 1'b1;
        end
        return r;
    endfunction

    forward_unit u_fwd_a (
        .ra          (RA1E),
        .wa_m        (WA3M),
        .wa_w        (WA3W),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd         (fwd_a)
    );

    forward_unit u_fwd_b (
        .ra          (RA2E),
        .wa_m        (WA3M),
        .wa_w        (WA3W),
        .reg_write_m (RegWriteM),
        .reg_write_w (RegWriteW),
        .fwd         (fwd_b)
    );

    assign ForwardAE = rst_n ? fwd_a : FWD_RF;
    assign ForwardBE = rst_n ? fwd_b : FWD_RF;

    // Controls decode from the registered state plus this cycle's hazards; reset holds them quiet.
    always_comb begin
        StallF           = 1'b0;
        StallD           = 1'b0;
        StallE           = 1'b0;
        StallM           = 1'b0;
        FlushD           = 1'b0;
        FlushE           = 1'b0;
        FlushW           = 1'b0;
        state_nxt        = state;
        pcw_nxt          = pcw_cnt;
        mem_hold         = 1'b0;
        timeout_hit      = 1'b0;
        mispredict_apply = 1'b0;
        load_use         = MemtoRegE && (WA3E != R15) && ((WA3E == RA1D) || (WA3E == RA2D));

        if (!rst_n) begin
            state_nxt = RUN;
        end else if (state == MEM_WAIT) begin
            if (!mem_ready) begin
                mem_hold = 1'b1;
                if (tmo_cnt == TMO_LAST) begin
                    timeout_hit = 1'b1;
                    state_nxt   = RUN;
                end
            end else if (pcw_cnt != '0) begin
                // PC write still in flight: keep fetch frozen and fall back into the drain
                StallF    = 1'b1;
                FlushD    = 1'b1;
                state_nxt = PC_WAIT;
            end else begin
                state_nxt = RUN;
            end
        end else if (MemAccessM && !mem_ready) begin
            mem_hold  = 1'b1;
            state_nxt = MEM_WAIT;
        end else begin
            mispredict_apply = MispredictE || pending_mispredict;
            if (state == PC_WAIT) begin
                StallF  = 1'b1;
                FlushD  = 1'b1;
                FlushE  = mispredict_apply;
                pcw_nxt = pcw_step(pcw_cnt, PCSrcD, PCWrPendingW);
                if (pcw_nxt == '0) begin
                    state_nxt = RUN;
                end
            end else if (mispredict_apply) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (PCSrcD) begin
                StallF    = 1'b1;
                FlushD    = 1'b1;
                pcw_nxt   = pcw_step(pcw_cnt, 1'b1, 1'b0);
                state_nxt = PC_WAIT;
            end else if (load_use) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end

        if (mem_hold) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= RUN;
            pcw_cnt            <= '0;
            tmo_cnt            <= '0;
            pending_mispredict <= 1'b0;
            mem_err            <= 1'b0;
            stall_cycles       <= '0;
            flush_events       <= '0;
        end else begin
            state   <= state_nxt;
            pcw_cnt <= pcw_nxt;
            tmo_cnt <= (state == MEM_WAIT && mem_hold && !timeout_hit) ? tmo_cnt + 1'b1 : '0;
            if (timeout_hit) begin
                mem_err <= 1'b1;
            end
            // A mispredict seen while memory holds the pipe is replayed once the pipe moves again
            if (mispredict_apply) begin
                pending_mispredict <= 1'b0;
            end else if (mem_hold && MispredictE) begin
                pending_mispredict <= 1'b1;
            end
            stall_cycles <= sat_inc(stall_cycles, StallF);
            flush_events <= sat_inc(flush_events, mispredict_apply);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: single-cycle vector table plus hand-written multi-cycle sequences.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic        MemtoRegE, RegWriteM, RegWriteW, PCSrcD, PCWrPendingW;
    logic        MispredictE, MemAccessM, mem_ready;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [15:0] stall_cycles, flush_events;
    logic        mem_err;
    logic [6:0]  ctl;

    // Control bundle order: {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_LU   = 7'b1100010;
    localparam logic [6:0] C_MIS  = 7'b0000110;
    localparam logic [6:0] C_MEM  = 7'b1111001;
    localparam logic [6:0] C_PC   = 7'b1000100;
    localparam logic [6:0] C_PCM  = 7'b1000110;

    typedef struct {
        string      name;
        logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
        logic       mtr, rwm, rww, mis, mem, rdy;
        logic [6:0] ctl;
        logic [1:0] fa, fb;
        logic       fe;
    } vec_t;

    typedef struct {
        string      name;
        logic [6:0] ctl;
        logic [1:0] fa, fb;
        logic       fe;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   exp_sc   = 0;
    int   exp_fe   = 0;
    logic exp_err  = 1'b0;

    assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

    pipeline_hazard_ctrl #(.CNT_W(16), .MEM_TIMEOUT(64), .PCW_DEPTH(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .MemtoRegE(MemtoRegE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .PCSrcD(PCSrcD), .PCWrPendingW(PCWrPendingW), .MispredictE(MispredictE),
        .MemAccessM(MemAccessM), .mem_ready(mem_ready),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .stall_cycles(stall_cycles), .flush_events(flush_events), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(string n, logic [3:0] ra1d, logic [3:0] ra2d, logic [3:0] ra1e,
                                logic [3:0] ra2e, logic [3:0] wa3e, logic [3:0] wa3m, logic [3:0] wa3w,
                                logic mtr, logic rwm, logic rww, logic mis, logic mem, logic rdy,
                                logic [6:0] c, logic [1:0] fa, logic [1:0] fb, logic fe);
        vec_t v;
        v.name = n; v.ra1d = ra1d; v.ra2d = ra2d; v.ra1e = ra1e; v.ra2e = ra2e;
        v.wa3e = wa3e; v.wa3m = wa3m; v.wa3w = wa3w;
        v.mtr = mtr; v.rwm = rwm; v.rww = rww; v.mis = mis; v.mem = mem; v.rdy = rdy;
        v.ctl = c; v.fa = fa; v.fb = fb; v.fe = fe;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic idle();
        RA1D = 4'd0; RA2D = 4'd0; RA1E = 4'd0; RA2E = 4'd0;
        WA3E = 4'd0; WA3M = 4'd0; WA3W = 4'd0;
        MemtoRegE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        PCSrcD = 1'b0; PCWrPendingW = 1'b0; MispredictE = 1'b0;
        MemAccessM = 1'b0; mem_ready = 1'b0;
    endtask

    // One clock: queue the expectation, compare at the falling edge, then advance the model
    task automatic cyc(input string nm, input logic [6:0] c, input logic [1:0] fa,
                       input logic [1:0] fb, input logic fe);
        exp_t e;
        e.name = nm; e.ctl = c; e.fa = fa; e.fb = fb; e.fe = fe;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        chk({e.name, ".ctl"}, 32'(ctl), 32'(e.ctl));
        chk({e.name, ".fwdA"}, 32'(ForwardAE), 32'(e.fa));
        chk({e.name, ".fwdB"}, 32'(ForwardBE), 32'(e.fb));
        chk({e.name, ".stall_cycles"}, 32'(stall_cycles), 32'(exp_sc));
        chk({e.name, ".flush_events"}, 32'(flush_events), 32'(exp_fe));
        chk({e.name, ".mem_err"}, 32'(mem_err), 32'(exp_err));
        exp_sc += int'(e.ctl[6]);
        exp_fe += int'(e.fe);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        // Reset with hazards presented on every input: controls and forwarding must stay quiet
        idle();
        rst_n = 1'b0;
        MemAccessM = 1'b1; MispredictE = 1'b1; PCSrcD = 1'b1;
        RegWriteM = 1'b1; WA3M = 4'd3; RA1E = 4'd3;
        #2;
        chk("reset.ctl", 32'(ctl), 32'(C_NONE));
        chk("reset.fwdA", 32'(ForwardAE), 32'd0);
        chk("reset.stall_cycles", 32'(stall_cycles), 32'd0);
        chk("reset.flush_events", 32'(flush_events), 32'd0);
        chk("reset.mem_err", 32'(mem_err), 32'd0);
        #10;
        idle();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        //           name           ra1d ra2d ra1e ra2e wa3e wa3m wa3w mtr rwm rww mis mem rdy ctl     fa     fb     fe
        vecs.push_back(mk("idle",       0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, C_NONE, 2'b00, 2'b00, 0));
        vecs.push_back(mk("fwd_m_pri",  8, 9, 3, 5, 0, 3, 3,  0, 1, 1, 0, 0, 0, C_NONE, 2'b10, 2'b00, 0));
        vecs.push_back(mk("fwd_w",      8, 9, 3, 5, 0, 3, 3,  0, 0, 1, 0, 0, 0, C_NONE, 2'b01, 2'b00, 0));
        vecs.push_back(mk("fwd_r15",    8, 9, 15, 15, 0, 15, 15, 0, 1, 1, 0, 0, 0, C_NONE, 2'b00, 2'b00, 0));
        vecs.push_back(mk("fwd_b_w",    8, 9, 4, 7, 0, 2, 7,  0, 1, 1, 0, 0, 0, C_NONE, 2'b00, 2'b01, 0));
        vecs.push_back(mk("fwd_b_m",    8, 9, 7, 2, 0, 2, 7,  0, 1, 1, 0, 0, 0, C_NONE, 2'b01, 2'b10, 0));
        vecs.push_back(mk("lu_ra1",     1, 2, 0, 0, 1, 0, 0,  1, 0, 0, 0, 0, 0, C_LU,   2'b00, 2'b00, 0));
        vecs.push_back(mk("lu_resume",  1, 2, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, C_NONE, 2'b00, 2'b00, 0));
        vecs.push_back(mk("lu_ra2",     3, 4, 0, 0, 4, 0, 0,  1, 0, 0, 0, 0, 0, C_LU,   2'b00, 2'b00, 0));
        vecs.push_back(mk("lu_r15",     15, 2, 0, 0, 15, 0, 0, 1, 0, 0, 0, 0, 0, C_NONE, 2'b00, 2'b00, 0));
        vecs.push_back(mk("no_load",    1, 2, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, C_NONE, 2'b00, 2'b00, 0));
        vecs.push_back(mk("mispredict", 8, 9, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, C_MIS,  2'b00, 2'b00, 1));
        vecs.push_back(mk("mis_over_lu", 1, 2, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, C_MIS,  2'b00, 2'b00, 1));
        vecs.push_back(mk("mem_hit",    8, 9, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 1, C_NONE, 2'b00, 2'b00, 0));
        vecs.push_back(mk("lu_and_fwd", 6, 9, 6, 0, 6, 6, 0,  1, 1, 0, 0, 0, 0, C_LU,   2'b10, 2'b00, 0));

        foreach (vecs[i]) begin
            idle();
            RA1D = vecs[i].ra1d; RA2D = vecs[i].ra2d; RA1E = vecs[i].ra1e; RA2E = vecs[i].ra2e;
            WA3E = vecs[i].wa3e; WA3M = vecs[i].wa3m; WA3W = vecs[i].wa3w;
            MemtoRegE = vecs[i].mtr; RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww;
            MispredictE = vecs[i].mis; MemAccessM = vecs[i].mem; mem_ready = vecs[i].rdy;
            cyc(vecs[i].name, vecs[i].ctl, vecs[i].fa, vecs[i].fb, vecs[i].fe);
        end

        // Memory wait of four cycles with a mispredict deferred until after mem_ready
        idle();
        MemAccessM = 1'b1;
        cyc("mw_0", C_MEM, 2'b00, 2'b00, 0);
        cyc("mw_1", C_MEM, 2'b00, 2'b00, 0);
        MispredictE = 1'b1;
        cyc("mw_2_mis", C_MEM, 2'b00, 2'b00, 0);
        MispredictE = 1'b0;
        cyc("mw_3", C_MEM, 2'b00, 2'b00, 0);
        mem_ready = 1'b1;
        cyc("mw_ready", C_NONE, 2'b00, 2'b00, 0);
        idle();
        cyc("mw_deferred_flush", C_MIS, 2'b00, 2'b00, 1);
        cyc("mw_flag_clear", C_NONE, 2'b00, 2'b00, 0);

        // Two PC writes in flight, drained by two retirements
        PCSrcD = 1'b1;
        cyc("pc_0", C_PC, 2'b00, 2'b00, 0);
        PCSrcD = 1'b0;
        cyc("pc_1", C_PC, 2'b00, 2'b00, 0);
        PCSrcD = 1'b1;
        cyc("pc_2", C_PC, 2'b00, 2'b00, 0);
        PCSrcD = 1'b0;
        cyc("pc_3", C_PC, 2'b00, 2'b00, 0);
        cyc("pc_4", C_PC, 2'b00, 2'b00, 0);
        PCWrPendingW = 1'b1;
        cyc("pc_5_ret", C_PC, 2'b00, 2'b00, 0);
        cyc("pc_6_ret", C_PC, 2'b00, 2'b00, 0);
        PCWrPendingW = 1'b0;
        cyc("pc_7_run", C_NONE, 2'b00, 2'b00, 0);

        // Memory wait preempting a PC-write drain, then a mispredict inside the drain
        PCSrcD = 1'b1;
        cyc("pm_0", C_PC, 2'b00, 2'b00, 0);
        PCSrcD = 1'b0; MemAccessM = 1'b1;
        cyc("pm_1_mem", C_MEM, 2'b00, 2'b00, 0);
        cyc("pm_2_mem", C_MEM, 2'b00, 2'b00, 0);
        mem_ready = 1'b1;
        cyc("pm_3_resume", C_PC, 2'b00, 2'b00, 0);
        idle();
        MispredictE = 1'b1;
        cyc("pm_4_mis", C_PCM, 2'b00, 2'b00, 1);
        MispredictE = 1'b0; PCWrPendingW = 1'b1;
        cyc("pm_5_ret", C_PC, 2'b00, 2'b00, 0);
        PCWrPendingW = 1'b0;
        cyc("pm_6_run", C_NONE, 2'b00, 2'b00, 0);

        // Stuck memory: one entry cycle plus 64 waiting cycles, then mem_err and back to RUN
        MemAccessM = 1'b1;
        for (int i = 0; i < 65; i++) begin
            cyc($sformatf("tmo_%0d", i), C_MEM, 2'b00, 2'b00, 0);
        end
        exp_err = 1'b1;
        MemAccessM = 1'b0;
        cyc("tmo_run", C_NONE, 2'b00, 2'b00, 0);
        cyc("tmo_sticky", C_NONE, 2'b00, 2'b00, 0);

        // Asynchronous reset while waiting on memory
        MemAccessM = 1'b1;
        cyc("rst_enter_mw", C_MEM, 2'b00, 2'b00, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst.ctl", 32'(ctl), 32'(C_NONE));
        chk("midrst.stall_cycles", 32'(stall_cycles), 32'd0);
        chk("midrst.flush_events", 32'(flush_events), 32'd0);
        chk("midrst.mem_err", 32'(mem_err), 32'd0);
        exp_sc = 0; exp_fe = 0; exp_err = 1'b0;
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc("post_rst_idle", C_NONE, 2'b00, 2'b00, 0);
        MispredictE = 1'b1;
        cyc("post_rst_mis", C_MIS, 2'b00, 2'b00, 1);
        idle();
        cyc("post_rst_end", C_NONE, 2'b00, 2'b00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central sequencer for the 5-stage ARM pipeline (F/D/E/M/W). It generates per-stage stall and flush controls, and forwarding selects for the execute-stage operands. It also tracks multi-cycle hazards: data-memory wait, in-flight R15 writes, and branch mispredicts deferred behind a memory stall. It sits beside the decode/control path and consumes its RegW/MemtoReg/PCSrc/Branch outputs as they travel down the pipe.

Parameters:
CNT_W, 16, width of the saturating performance counters
MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before mem_err is raised
PCW_DEPTH, 3, pipeline distance D->W used to size the in-flight PC-write counter (2 bits sufficient)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
RA1D, RA2D  in  4 each  decode-stage source register numbers
RA1E, RA2E  in  4 each  execute-stage source register numbers
WA3E, WA3M, WA3W  in  4 each  destination register per stage
MemtoRegE  in  1  execute-stage instruction is a load
RegWriteM, RegWriteW  in  1 each  register write enable per stage
PCSrcD, PCWrPendingW  in  1 each  R15 write decoded / R15 write retiring in W
MispredictE  in  1  branch resolved in E disagrees with prediction
MemAccessM  in  1  M-stage instruction accesses data memory
mem_ready  in  1  data memory completes the access this cycle
StallF, StallD, StallE, StallM  out  1 each  hold stage register
FlushD, FlushE, FlushW  out  1 each  bubble into stage register
ForwardAE, ForwardBE  out  2 each  00 reg file, 01 from W, 10 from M
stall_cycles  out  CNT_W  saturating count of cycles with StallF=1
flush_events  out  CNT_W  saturating count of mispredict flushes applied
mem_err  out  1  sticky timeout flag

Behaviour:
- Reset (async, rst_n=0): state=RUN, all stall/flush=0, Forward*=00, counters=0, mem_err=0, pending_mispredict=0, pcw_cnt=0. Effect is immediate and the block resumes in RUN on the first edge after release. Reset mid-MEM_WAIT drops the wait without raising mem_err.
- Forwarding (combinational, all states): ForwardAE=10 if RegWriteM && WA3M==RA1E; else 01 if RegWriteW && WA3W==RA1E; else 00. M has priority over W. ForwardBE uses the same rule with RA2E. Register 15 is never forwarded (00).
- States: RUN, MEM_WAIT, PC_WAIT.
- Priority each cycle: memory wait > mispredict > PC write > load-use.
- RUN:
  - MemAccessM && !mem_ready -> MEM_WAIT. In the same cycle assert StallF..StallM=1 and FlushW=1.
  - Else if MispredictE: assert FlushD=FlushE=1 for exactly one cycle, and increment flush_events.
  - Else if PCSrcD: pcw_cnt+=1, then go to PC_WAIT. Assert StallF=1 and FlushD=1.
  - Else load-use (MemtoRegE && WA3E!=0xF && (WA3E==RA1D || WA3E==RA2D)): assert StallF=StallD=1 and FlushE=1 for one cycle, then stay in RUN.
- MEM_WAIT:
  - StallF..StallM=1 and FlushW=1 every cycle.
  - MispredictE arriving here sets pending_mispredict.
  - On mem_ready: return to RUN. On the next cycle, if pending_mispredict, apply FlushD=FlushE, increment flush_events, and clear the flag.
  - A timeout counter increments each cycle. At MEM_TIMEOUT it sets mem_err=1 (sticky) and forces return to RUN.
- PC_WAIT:
  - StallF=1 and FlushD=1 each cycle.
  - Another PCSrcD increments pcw_cnt. PCWrPendingW decrements it.
  - PCSrcD and PCWrPendingW in the same cycle leave pcw_cnt unchanged.
  - When pcw_cnt reaches 0: go to RUN, and release StallF in the next cycle.
  - A memory wait preempts PC_WAIT (go to MEM_WAIT; pcw_cnt is kept) and the block resumes PC_WAIT afterwards.
  - MispredictE in PC_WAIT flushes D/E and clears pcw_cnt only for PC writes younger than E; the simple rule used is that pcw_cnt is kept and PCWrPendingW still drains it.
- Counters: stall_cycles increments when StallF=1, and flush_events increments on each applied mispredict flush. Both saturate at all-ones with no wrap.
- Stall and flush outputs are registered-state-driven combinational decodes with zero added latency. Forwarding is purely combinational.

Decomposition:
- Shared package: state encoding (RUN=2'd0, MEM_WAIT=2'd1, PC_WAIT=2'd2), forward select constants (FWD_RF, FWD_W, FWD_M), and the R15 index constant.
- One sub-module, forward_unit: purely combinational, instantiated with two port sets for A and B.
- Counters and the FSM stay in the top module.

Test Plan:
- Load-use: LDR R1 in E (MemtoRegE=1, WA3E=1), RA1D=1 -> exactly 1 cycle of StallF=StallD=FlushE=1, then the pipe resumes and stall_cycles=1.
- Forward priority: RegWriteM=RegWriteW=1, WA3M=WA3W=RA1E=3 -> ForwardAE=10. Then drop RegWriteM -> ForwardAE=01. With RA1E=15 -> ForwardAE=00.
- Memory wait with deferred mispredict: MemAccessM=1, mem_ready low for 4 cycles, MispredictE pulsed in cycle 2 -> 4 cycles of StallF..StallM=1 and FlushW=1. The cycle after mem_ready gives FlushD=FlushE=1 and flush_events=1.
- PC write: two PCSrcD pulses 1 cycle apart, then PCWrPendingW pulses 3 and 4 cycles later -> StallF=FlushD=1 until the cycle after the second PCWrPendingW, then state RUN.
- Timeout: MemAccessM=1 with mem_ready stuck low -> mem_err rises after exactly 64 cycles, state returns to RUN, and mem_err stays 1 until rst_n=0.
- Reset mid-operation: assert rst_n=0 during MEM_WAIT -> all outputs 0 asynchronously, and counters 0. After release with MemAccessM=0 -> no stall.
